// File: rtl/alu_issue_regfile.sv
// Single-issue operand fetch / writeback stage around an external combinational
// 16-bit ALU. Owns the register file, accepts one instruction at a time
// (IDLE -> READ -> EXEC), and latches the ALU Zero/Overflow outputs as flags.
// Optional feature macro: STICKY_OVF_EN adds ovf_clr / ovf_sticky.
module alu_issue_regfile #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = 3
) (
`ifdef STICKY_OVF_EN
    input  logic          ovf_clr,
    output logic          ovf_sticky,
`endif
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_ctrl,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic [AW-1:0] in_rd,
    input  logic          in_imm_sel,
    input  logic [15:0]   in_imm,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [15:0]   ld_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data,
    output logic [15:0]   alu_a,
    output logic [15:0]   alu_b,
    output logic [3:0]    alu_ctrl,
    input  logic [15:0]   alu_s,
    input  logic          alu_overflow,
    input  logic          alu_zero,
    output logic          done,
    output logic          flag_zero,
    output logic          flag_ovf
);

    typedef enum logic [1:0] {StIdle, StRead, StExec} state_e;

    state_e        state_q;
    logic [15:0]   regs_q [NREGS];

    // Instruction fields captured at accept
    logic [3:0]    ins_ctrl_q;
    logic [AW-1:0] ins_rs_q;
    logic [AW-1:0] ins_rt_q;
    logic [AW-1:0] ins_rd_q;
    logic          ins_imm_sel_q;
    logic [15:0]   ins_imm_q;

    // ALU-facing operands, only updated in READ so they hold outside EXEC
    logic [15:0]   op_a_q;
    logic [15:0]   op_b_q;
    logic [3:0]    ctrl_q;

    logic          done_q;
    logic          flag_zero_q;
    logic          flag_ovf_q;
    logic          accept;

    assign in_ready = (state_q == StIdle);
    assign accept   = in_valid & in_ready;
    assign alu_a    = op_a_q;
    assign alu_b    = op_b_q;
    assign alu_ctrl = ctrl_q;
    assign done     = done_q;
    assign flag_zero = flag_zero_q;
    assign flag_ovf  = flag_ovf_q;
    assign dbg_data  = regs_q[dbg_addr];

    // Issue FSM with registered operand, flag and done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ins_ctrl_q    <= '0;
            ins_rs_q      <= '0;
            ins_rt_q      <= '0;
            ins_rd_q      <= '0;
            ins_imm_sel_q <= 1'b0;
            ins_imm_q     <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            ctrl_q        <= '0;
            done_q        <= 1'b0;
            flag_zero_q   <= 1'b0;
            flag_ovf_q    <= 1'b0;
`ifdef STICKY_OVF_EN
            ovf_sticky    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        ins_ctrl_q    <= in_ctrl;
                        ins_rs_q      <= in_rs;
                        ins_rt_q      <= in_rt;
                        ins_rd_q      <= in_rd;
                        ins_imm_sel_q <= in_imm_sel;
                        ins_imm_q     <= in_imm;
                        state_q       <= StRead;
                    end
                end
                StRead: begin
                    // A load accepted alongside the instruction is already visible here
                    op_a_q  <= regs_q[ins_rs_q];
                    op_b_q  <= ins_imm_sel_q ? ins_imm_q : regs_q[ins_rt_q];
                    ctrl_q  <= ins_ctrl_q;
                    state_q <= StExec;
                end
                StExec: begin
                    flag_zero_q <= alu_zero;
                    flag_ovf_q  <= alu_overflow;
                    done_q      <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
`ifdef STICKY_OVF_EN
            // Set wins over a same-cycle clear
            if (state_q == StExec && alu_overflow) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
`endif
        end
    end

    // Register file: writeback in EXEC, host loads only in IDLE (never coincide)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == StExec) begin
            regs_q[ins_rd_q] <= alu_s;
        end else if (state_q == StIdle && ld_en) begin
            regs_q[ld_addr] <= ld_data;
        end
    end

endmodule

// File: tb/tb_alu_issue_regfile.sv
// Self-checking bench for alu_issue_regfile with a small behavioural ALU.
// ALU codes modelled: 0000 sub (ovf = borrow), 0001 add (ovf = carry out),
// 0010 and, 0011 or.
module tb_alu_issue_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctrl;
    logic [2:0]  in_rs, in_rt, in_rd;
    logic        in_imm_sel;
    logic [15:0] in_imm;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] alu_a, alu_b, alu_s;
    logic [3:0]  alu_ctrl;
    logic        alu_overflow, alu_zero;
    logic        done, flag_zero, flag_ovf;
`ifdef STICKY_OVF_EN
    logic        ovf_clr;
    logic        ovf_sticky;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_issue_regfile #(.NREGS(8), .AW(3)) dut (
`ifdef STICKY_OVF_EN
        .ovf_clr      (ovf_clr),
        .ovf_sticky   (ovf_sticky),
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ctrl      (in_ctrl),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rd        (in_rd),
        .in_imm_sel   (in_imm_sel),
        .in_imm       (in_imm),
        .ld_en        (ld_en),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_s        (alu_s),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero),
        .done         (done),
        .flag_zero    (flag_zero),
        .flag_ovf     (flag_ovf)
    );

    // Behavioural ALU
    logic [16:0] alu_wide;
    always_comb begin
        alu_wide     = '0;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            4'b0000: begin
                alu_wide     = {1'b0, alu_a} - {1'b0, alu_b};
                alu_overflow = alu_wide[16];
            end
            4'b0001: begin
                alu_wide     = {1'b0, alu_a} + {1'b0, alu_b};
                alu_overflow = alu_wide[16];
            end
            4'b0010: alu_wide = {1'b0, alu_a & alu_b};
            4'b0011: alu_wide = {1'b0, alu_a | alu_b};
            default: alu_wide = '0;
        endcase
        alu_s    = alu_wide[15:0];
        alu_zero = (alu_wide[15:0] == 16'h0000);
    end

    typedef struct {
        logic [3:0]  ctrl;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic        imm_sel;
        logic [15:0] imm;
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] es;
        logic        ez;
        logic        eo;
    } vec_t;

    vec_t tv[7];
    vec_t cv[3];
    vec_t v;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic rd_reg(input logic [2:0] a, input logic [15:0] exp, input string name);
        dbg_addr = a;
        #1;
        chk(name, dbg_data, exp);
    endtask

    task automatic set_fields(input vec_t x);
        in_ctrl    = x.ctrl;
        in_rs      = x.rs;
        in_rt      = x.rt;
        in_rd      = x.rd;
        in_imm_sel = x.imm_sel;
        in_imm     = x.imm;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // Issue one instruction from IDLE and check every stage of it
    task automatic do_vec(input vec_t x, input string tag);
        chk({tag, " ready_idle"}, in_ready, 1);
        set_fields(x);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ld_en    = 1'b0;
        chk({tag, " ready_read"}, in_ready, 0);
        @(posedge clk); #1;
        chk({tag, " alu_a"}, alu_a, x.ea);
        chk({tag, " alu_b"}, alu_b, x.eb);
        chk({tag, " alu_ctrl"}, alu_ctrl, x.ctrl);
        chk({tag, " done_exec"}, done, 0);
        @(posedge clk); #1;
        chk({tag, " done"}, done, 1);
        chk({tag, " ready_back"}, in_ready, 1);
        chk({tag, " zero"}, flag_zero, x.ez);
        chk({tag, " ovf"}, flag_ovf, x.eo);
        rd_reg(x.rd, x.es, {tag, " rd"});
        @(posedge clk); #1;
        chk({tag, " done_off"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc[3];
        int k;
        int dn;
        logic took;

        //          ctrl     rs    rt    rd   isel  imm       a         b         s        z     o
        tv[0] = '{4'b0001, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0000, 16'h1234, 16'h0F0F, 16'h2143, 1'b0, 1'b0};
        tv[1] = '{4'b0000, 3'd1, 3'd2, 3'd4, 1'b0, 16'h0000, 16'h1234, 16'h0F0F, 16'h0325, 1'b0, 1'b0};
        tv[2] = '{4'b0000, 3'd2, 3'd2, 3'd5, 1'b0, 16'h0000, 16'h0F0F, 16'h0F0F, 16'h0000, 1'b1, 1'b0};
        tv[3] = '{4'b0001, 3'd3, 3'd0, 3'd6, 1'b1, 16'h00BD, 16'h2143, 16'h00BD, 16'h2200, 1'b0, 1'b0};
        tv[4] = '{4'b0001, 3'd1, 3'd1, 3'd1, 1'b0, 16'h0000, 16'h1234, 16'h1234, 16'h2468, 1'b0, 1'b0};
        tv[5] = '{4'b0001, 3'd0, 3'd0, 3'd0, 1'b1, 16'h5A5A, 16'h0000, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0};
        tv[6] = '{4'b0010, 3'd2, 3'd0, 3'd7, 1'b1, 16'h00FF, 16'h0F0F, 16'h00FF, 16'h000F, 1'b0, 1'b0};
        // Back-to-back stream; cv[1] depends on cv[0]'s result
        cv[0] = '{4'b0001, 3'd3, 3'd0, 3'd2, 1'b1, 16'h0001, 16'h2143, 16'h0001, 16'h2144, 1'b0, 1'b0};
        cv[1] = '{4'b0000, 3'd2, 3'd3, 3'd5, 1'b0, 16'h0000, 16'h2144, 16'h2143, 16'h0001, 1'b0, 1'b0};
        cv[2] = '{4'b0011, 3'd5, 3'd0, 3'd6, 1'b1, 16'hF000, 16'h0001, 16'hF000, 16'hF001, 1'b0, 1'b0};

        // Reset with in_valid held high
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_ctrl = 4'b0001; in_rs = 3'd1; in_rt = 3'd2; in_rd = 3'd3;
        in_imm_sel = 1'b0; in_imm = 16'h0000;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
`ifdef STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", in_ready, 1);
        chk("rst done", done, 0);
        chk("rst flag_zero", flag_zero, 0);
        chk("rst flag_ovf", flag_ovf, 0);
        chk("rst alu_a", alu_a, 16'h0000);
        chk("rst alu_b", alu_b, 16'h0000);
        chk("rst alu_ctrl", alu_ctrl, 4'b0000);
`ifdef STICKY_OVF_EN
        chk("rst ovf_sticky", ovf_sticky, 0);
`endif
        for (int i = 0; i < 8; i++) begin
            rd_reg(3'(i), 16'h0000, $sformatf("rst r%0d", i));
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post rst in_ready", in_ready, 1);

        // Table-driven instructions
        load(3'd1, 16'h1234);
        load(3'd2, 16'h0F0F);
        for (int i = 0; i < 7; i++) begin
            do_vec(tv[i], $sformatf("vec%0d", i));
        end

        // Carry out: 0xFFFF + 1
        load(3'd1, 16'hFFFF);
        v = '{4'b0001, 3'd1, 3'd0, 3'd1, 1'b1, 16'h0001, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        do_vec(v, "carry");
`ifdef STICKY_OVF_EN
        chk("sticky set", ovf_sticky, 1);
`endif

        // in_valid held high: accepts must be exactly 3 cycles apart
        k = 0;
        dn = 0;
        set_fields(cv[0]);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            took = 1'b0;
            if (in_valid && in_ready) begin
                if (k < 3) acc[k] = cyc;
                k++;
                took = 1'b1;
            end
            if (done) dn++;
            @(posedge clk); #1;
            if (took) begin
                if (k < 3) set_fields(cv[k]);
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("stream accepts", k, 3);
        chk("stream gap01", acc[1] - acc[0], 3);
        chk("stream gap12", acc[2] - acc[1], 3);
        chk("stream done pulses", dn, 2);
        chk("stream last done", done, 1);
        rd_reg(3'd2, 16'h2144, "stream r2");
        rd_reg(3'd5, 16'h0001, "stream r5");
        rd_reg(3'd6, 16'hF001, "stream r6");
        @(posedge clk); #1;
`ifdef STICKY_OVF_EN
        chk("sticky hold", ovf_sticky, 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("sticky clr", ovf_sticky, 0);
`endif

        // Loads during READ/EXEC are dropped
        v = '{4'b0001, 3'd6, 3'd5, 3'd7, 1'b0, 16'h0000, 16'hF001, 16'h0001, 16'hF002, 1'b0, 1'b0};
        set_fields(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 3'd7; ld_data = 16'hBEEF;
        @(posedge clk); #1;
        rd_reg(3'd7, 16'h000F, "drop r7 exec");
        @(posedge clk); #1;
        ld_en = 1'b0;
        rd_reg(3'd7, 16'hF002, "drop r7 wb");
        chk("drop done", done, 1);
        @(posedge clk); #1;

        // Load in the accept cycle is seen by READ
        ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'h0100;
        v = '{4'b0001, 3'd5, 3'd5, 3'd4, 1'b0, 16'h0000, 16'h0100, 16'h0100, 16'h0200, 1'b0, 1'b0};
        do_vec(v, "ldacc");

        // Reset during EXEC abandons the instruction
        load(3'd4, 16'h00AA);
        v = '{4'b0000, 3'd4, 3'd5, 3'd4, 1'b0, 16'h0000, 16'h00AA, 16'h0100, 16'hFFAA, 1'b0, 1'b1};
        set_fields(v);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst alu_a", alu_a, 16'h00AA);
        rst_n = 1'b0;
        #1;
        rd_reg(3'd4, 16'h0000, "midrst r4");
        chk("midrst done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst done c%0d", i), done, 0);
        end
        rd_reg(3'd4, 16'h0000, "midrst r4 after");
        chk("midrst ready", in_ready, 1);
        chk("midrst ovf", flag_ovf, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_regfile.md
Name: alu_issue_regfile

Overview:
- Single-issue operand/writeback stage wrapped around the combinational 16-bit ALU.
- Holds the architectural register file and accepts one ALU instruction at a time over a valid/ready handshake.
- Reads both source operands, drives the ALU operand/control inputs, and writes the ALU result back to the destination register.
- Latches the ALU Zero/Overflow outputs into status flags.

Parameters:
- NREGS, 8, number of 16-bit registers (power of two, >=2)
- AW, 3, register address width, equal to log2(NREGS)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instruction valid
- in_ready  output  1  block can accept an instruction
- in_ctrl  input  4  ALU control code, passed unchanged to the ALU
- in_rs  input  AW  source register for ALU A
- in_rt  input  AW  source register for ALU B
- in_rd  input  AW  destination register
- in_imm_sel  input  1  1: ALU B = in_imm instead of reg[rt]
- in_imm  input  16  immediate operand
- ld_en  input  1  host register load strobe
- ld_addr  input  AW  host load address
- ld_data  input  16  host load data
- dbg_addr  input  AW  debug read address
- dbg_data  output  16  combinational reg[dbg_addr]
- alu_a  output  16  to ALU A
- alu_b  output  16  to ALU B
- alu_ctrl  output  4  to ALU_Control
- alu_s  input  16  from ALU S
- alu_overflow  input  1  from ALU Overflow
- alu_zero  input  1  from ALU Zero
- done  output  1  one-cycle pulse after writeback
- flag_zero  output  1  Zero flag of last completed instruction
- flag_ovf  output  1  Overflow flag of last completed instruction

Behaviour:
- Reset (async assert, sync release):
  - All registers = 0x0000, state = IDLE.
  - done, flag_zero, flag_ovf = 0; in_ready = 1.
  - alu_a, alu_b = 0x0000; alu_ctrl = 4'b0000.
- FSM states IDLE, READ, EXEC. in_ready = (state==IDLE).
- IDLE:
  - On in_valid & in_ready, latch ctrl, rs, rt, rd, imm_sel, imm and go to READ.
  - in_valid is ignored in all other states.
- READ:
  - op_a_q <= reg[rs].
  - op_b_q <= imm_sel ? imm : reg[rt].
  - ctrl_q driven. Go to EXEC.
- EXEC:
  - alu_a = op_a_q, alu_b = op_b_q, alu_ctrl = ctrl_q, all registered, so they are stable for the whole cycle.
  - At the end of the cycle: reg[rd] <= alu_s; flag_zero <= alu_zero; flag_ovf <= alu_overflow.
  - Go to IDLE.
- done = 1 for exactly the cycle after EXEC, the same cycle in_ready returns to 1.
- Latency: accept edge to writeback edge = 2 cycles. Throughput = 1 instruction per 3 cycles.
- alu_a, alu_b and alu_ctrl hold their values outside EXEC (no glitching to 0).
- rd == rs or rd == rt: allowed. Operands are captured in READ, so writeback does not disturb them.
- Host load:
  - Honoured only in IDLE; ignored (dropped) in READ/EXEC.
  - Same-cycle ld_en and instruction accept in IDLE: the load completes and the accepted instruction's READ sees the loaded value.
- Writeback and load never coincide, because loads are blocked outside IDLE.
- dbg_data: combinational read; it reflects a write starting the cycle after the write edge.
- Reset mid-instruction: the instruction is abandoned, no writeback occurs, and done stays 0.
- Register 0 is an ordinary read/write register (not hardwired).

Optional Feature:
- Macro STICKY_OVF_EN.
- When defined:
  - Adds input ovf_clr (1) and output ovf_sticky (1).
  - ovf_sticky is set on any EXEC with alu_overflow = 1 and is cleared only by ovf_clr or reset.
  - Set has priority over a same-cycle ovf_clr.
- When undefined: neither port exists; flag_ovf behaviour is unchanged.

Test Plan:
- Reset with in_valid = 1 held -> in_ready = 1, all dbg reads = 0x0000, flags = 0, done = 0; no instruction is accepted while rst_n = 0.
- Load r1 = 0x1234, r2 = 0x0F0F; issue ctrl = 4'b0001 (add), rs = 1, rt = 2, rd = 3 -> alu_a = 0x1234 and alu_b = 0x0F0F during EXEC, r3 = 0x2143 two edges after accept, done pulses once, flag_zero = 0.
- Load r1 = 0xFFFF; issue add with imm_sel = 1, imm = 0x0001, rd = 1 -> r1 = 0x0000, flag_zero = 1, flag_ovf = 1 (carry out).
- Hold in_valid = 1 continuously with three different instructions -> accepts are spaced exactly 3 cycles apart; in_valid is ignored in READ/EXEC.
- ld_en = 1 during READ/EXEC targeting rd -> load dropped; rd holds the ALU result. ld_en with accept in IDLE -> READ uses the new value.
- Assert rst_n = 0 during EXEC of sub (4'b0000) into r4 (preloaded 0x00AA) -> r4 = 0x0000 (reset value), done never pulses; with STICKY_OVF_EN, ovf_sticky is set by the overflow case above and clears on a single-cycle ovf_clr.
